// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: widths, ALU op codes,
// MDU op codes and FSM state encodings.
package mdu_seq_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        MDU_MUL   = 2'd0,
        MDU_MULHU = 2'd1,
        MDU_DIVU  = 2'd2,
        MDU_REMU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Upper op bit selects the divide family (DIVU/REMU).
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_seq_alu.sv
// Shared 32-bit ALU slice: purely combinational ADD/SUB with overflow and
// zero flags.
module mdu_seq_alu
    import mdu_seq_pkg::*;
(
    input  logic [1:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            overflow,
    output logic            zero
);

    always_comb begin
        y        = a + b;
        overflow = (a[XLEN-1] == b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]);
        if (ctrl == ALU_SUB) begin
            y        = a - b;
            overflow = (a[XLEN-1] != b[XLEN-1]) && (y[XLEN-1] != a[XLEN-1]);
        end
        zero = (y == '0);
    end

endmodule

// File: rtl/mdu_seq.sv
// Radix-2 multiply/divide sequencer: one shift-add or restoring-divide step
// per cycle through the shared ALU, 33-cycle start-to-done latency.
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
    logic [XLEN-1:0]   hi_q, hi_d;       // acc_hi or remainder
    logic [XLEN-1:0]   lo_q, lo_d;       // multiplier or quotient
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [1:0]        alu_ctrl;
    logic [XLEN-1:0]   alu_a, alu_b, alu_y;
    logic              alu_ovf, alu_zero;
    logic [XLEN-1:0]   rem_sh;
    logic              take, carry;
    logic [XLEN-1:0]   step_hi, step_lo;

    mdu_seq_alu u_alu (
        .ctrl     (alu_ctrl),
        .a        (alu_a),
        .b        (alu_b),
        .y        (alu_y),
        .overflow (alu_ovf),
        .zero     (alu_zero)
    );

    logic unused_alu_flags;
    assign unused_alu_flags = alu_ovf ^ alu_zero;

    always_comb begin
        rem_sh = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        take   = 1'b0;
        carry  = 1'b0;
        if (op_is_div(op_q)) begin
            alu_ctrl = ALU_SUB;
            alu_a    = rem_sh;
            alu_b    = opnd_q;
            take     = hi_q[XLEN-1] | ~(rem_sh < opnd_q);
            step_hi  = take ? alu_y : rem_sh;
            step_lo  = {lo_q[XLEN-2:0], take};
        end else begin
            alu_ctrl = ALU_ADD;
            alu_a    = hi_q;
            alu_b    = lo_q[0] ? opnd_q : '0;
            carry    = (alu_y < hi_q);
            step_hi  = {carry, alu_y[XLEN-1:1]};
            step_lo  = {alu_y[0], lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    hi_d   = '0;
                    busy_d = 1'b1;
                    lo_d   = op_is_div(op) ? src_a : src_b;
                    opnd_d = op_is_div(op) ? src_b : src_a;
                    if (op_is_div(op) && (src_b == '0)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = (op == MDU_DIVU) ? '1 : src_a;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    // MULHU and REMU take the high register, MUL and DIVU the low.
                    result_d = op_q[0] ? step_hi : step_lo;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (kill) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
